// File: rtl/ag32gbd_pkg.sv
// ag32gbd frame scanner shared definitions.
// State encoding, default geometry and frame-buffer address width.
package ag32gbd_pkg;

  localparam int DEF_IMG_W = 128;
  localparam int DEF_IMG_H = 112;
  localparam int BUF_AW    = 12;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ      = 3'd1;
  localparam logic [2:0] S_WAIT_LOW = 3'd2;
  localparam logic [2:0] S_STORE    = 3'd3;
  localparam logic [2:0] S_NEXT     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  typedef struct packed {
    logic [6:0] x;
    logic [6:0] y;
    logic [1:0] val;
  } pixel_t;

endpackage

// File: rtl/ag32gbd_frame_scanner_if.sv
// Sampler handshake and frame-buffer write bus of the frame scanner.
// master = scanner, slave = sampler / frame buffer side.
interface ag32gbd_frame_scanner_if;
  import ag32gbd_pkg::*;

  logic              SampleStart;
  logic [6:0]        PixelX;
  logic [6:0]        PixelY;
  logic              SampleDone;
  logic [1:0]        SampledValue;
  logic              BufWe;
  logic [BUF_AW-1:0] BufAddr;
  logic [7:0]        BufData;

  modport master (
    output SampleStart, PixelX, PixelY,
    output BufWe, BufAddr, BufData,
    input  SampleDone, SampledValue
  );

  modport slave (
    input  SampleStart, PixelX, PixelY,
    input  BufWe, BufAddr, BufData,
    output SampleDone, SampledValue
  );

endinterface

// File: rtl/ag32gbd_pixel_packer.sv
// Packs 2-bit pixels into frame-buffer bytes and generates addresses.
// AG32GBD_TILE_FORMAT_EN selects Game Boy 2bpp tile layout over linear.
module ag32gbd_pixel_packer
  import ag32gbd_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W
) (
  input  logic              sys_clock,
  input  logic              sys_resetn,
  input  logic              clear,
  input  logic              store,
  input  pixel_t            pix,
  output logic              bufWe,
  output logic [BUF_AW-1:0] bufAddr,
  output logic [7:0]        bufData,
  output logic              pending
);

`ifdef AG32GBD_TILE_FORMAT_EN
  logic [6:0]        loSh;
  logic [6:0]        hiSh;
  logic [7:0]        hiHold;
  logic [BUF_AW-1:0] tileRow;
  logic [BUF_AW-1:0] tileAddr;

  assign tileRow = BUF_AW'(pix.y[6:3]) * BUF_AW'(IMG_W / 8)
                 + BUF_AW'(pix.x[6:3]);
  assign tileAddr = (tileRow << 4)
                  + BUF_AW'({pix.y[2:0], 1'b0});

  // hi plane byte follows the lo byte one cycle later
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      loSh    <= '0;
      hiSh    <= '0;
      hiHold  <= '0;
      bufWe   <= 1'b0;
      bufAddr <= '0;
      bufData <= '0;
      pending <= 1'b0;
    end else if (clear) begin
      loSh    <= '0;
      hiSh    <= '0;
      bufWe   <= 1'b0;
      pending <= 1'b0;
    end else if (pending) begin
      bufWe   <= 1'b1;
      bufAddr <= bufAddr + BUF_AW'(1);
      bufData <= hiHold;
      pending <= 1'b0;
    end else if (store) begin
      loSh  <= {loSh[5:0], pix.val[0]};
      hiSh  <= {hiSh[5:0], pix.val[1]};
      bufWe <= (pix.x[2:0] == 3'd7);
      if (pix.x[2:0] == 3'd7) begin
        bufAddr <= tileAddr;
        bufData <= {loSh, pix.val[0]};
        hiHold  <= {hiSh, pix.val[1]};
        pending <= 1'b1;
      end
    end else begin
      bufWe <= 1'b0;
    end
  end
`else
  logic [5:0]        sh;
  logic [BUF_AW-1:0] linAddr;

  assign linAddr = BUF_AW'(pix.y) * BUF_AW'(IMG_W / 4)
                 + BUF_AW'(pix.x[6:2]);
  assign pending = 1'b0;

  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      sh      <= '0;
      bufWe   <= 1'b0;
      bufAddr <= '0;
      bufData <= '0;
    end else if (clear) begin
      sh    <= '0;
      bufWe <= 1'b0;
    end else if (store) begin
      sh    <= {sh[3:0], pix.val};
      bufWe <= (pix.x[1:0] == 2'd3);
      if (pix.x[1:0] == 2'd3) begin
        bufAddr <= linAddr;
        bufData <= {sh, pix.val};
      end
    end else begin
      bufWe <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/ag32gbd_frame_scanner.sv
// Raster frame scanner: requests one sample per pixel, packs to buffer.
// Optional AG32GBD_TILE_FORMAT_EN selects tile layout in the packer.
module ag32gbd_frame_scanner
  import ag32gbd_pkg::*;
#(
  parameter int IMG_W          = DEF_IMG_W,
  parameter int IMG_H          = DEF_IMG_H,
  parameter int SAMPLE_TIMEOUT = 4095
) (
  input  logic sys_clock,
  input  logic sys_resetn,
  input  logic FrameStart,
  input  logic FrameAbort,
  output logic FrameBusy,
  output logic FrameDone,
  output logic TimeoutFlag,
  ag32gbd_frame_scanner_if.master bus
);

  localparam logic [6:0]  X_LAST  = 7'(IMG_W - 1);
  localparam logic [6:0]  Y_LAST  = 7'(IMG_H - 1);
  localparam logic [15:0] TO_LAST = 16'(SAMPLE_TIMEOUT - 1);

  logic [2:0]        state;
  logic              startQ;
  logic              sampleStart;
  logic [6:0]        pixX;
  logic [6:0]        pixY;
  logic [1:0]        pixVal;
  logic [15:0]       toCnt;
  logic              startAcc;
  logic              abort;
  logic              lastPix;
  logic              pending;
  logic              bufWe;
  logic [BUF_AW-1:0] bufAddr;
  logic [7:0]        bufData;

  assign abort    = FrameAbort && (state != S_IDLE);
  assign startAcc = (state == S_IDLE) && FrameStart
                 && !startQ && !FrameAbort;
  assign lastPix  = (pixX == X_LAST) && (pixY == Y_LAST);

  assign FrameBusy = (state != S_IDLE) && (state != S_DONE);
  assign FrameDone = (state == S_DONE) && !FrameAbort;

  assign bus.SampleStart = sampleStart;
  assign bus.PixelX      = pixX;
  assign bus.PixelY      = pixY;
  assign bus.BufWe       = bufWe;
  assign bus.BufAddr     = bufAddr;
  assign bus.BufData     = bufData;

  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state       <= S_IDLE;
      startQ      <= 1'b0;
      sampleStart <= 1'b0;
      pixX        <= '0;
      pixY        <= '0;
      pixVal      <= '0;
      toCnt       <= '0;
      TimeoutFlag <= 1'b0;
    end else begin
      startQ <= FrameStart;
      if (abort) begin
        state       <= S_IDLE;
        sampleStart <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: if (startAcc) begin
            state       <= S_REQ;
            sampleStart <= 1'b1;
            pixX        <= '0;
            pixY        <= '0;
            toCnt       <= '0;
            TimeoutFlag <= 1'b0;
          end
          // a silent sampler stores shade 0 and the scan moves on
          S_REQ: if (bus.SampleDone) begin
            pixVal      <= bus.SampledValue;
            sampleStart <= 1'b0;
            state       <= S_WAIT_LOW;
          end else if (toCnt == TO_LAST) begin
            pixVal      <= 2'b00;
            TimeoutFlag <= 1'b1;
            sampleStart <= 1'b0;
            state       <= S_WAIT_LOW;
          end else begin
            toCnt <= toCnt + 16'd1;
          end
          S_WAIT_LOW: if (!bus.SampleDone) state <= S_STORE;
          S_STORE: state <= S_NEXT;
          S_NEXT: if (!pending) begin
            if (lastPix) begin
              state <= S_DONE;
            end else begin
              if (pixX == X_LAST) begin
                pixX <= '0;
                pixY <= pixY + 7'd1;
              end else begin
                pixX <= pixX + 7'd1;
              end
              state       <= S_REQ;
              sampleStart <= 1'b1;
              toCnt       <= '0;
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  ag32gbd_pixel_packer #(
    .IMG_W (IMG_W)
  ) u_packer (
    .sys_clock  (sys_clock),
    .sys_resetn (sys_resetn),
    .clear      (abort || startAcc),
    .store      (state == S_STORE),
    .pix        ('{x: pixX, y: pixY, val: pixVal}),
    .bufWe      (bufWe),
    .bufAddr    (bufAddr),
    .bufData    (bufData),
    .pending    (pending)
  );

endmodule

// File: tb/tb_ag32gbd_frame_scanner.sv
// Self-checking bench for ag32gbd_frame_scanner (32x16 frame).
// Honours AG32GBD_TILE_FORMAT_EN for the expected byte layout.
module tb_ag32gbd_frame_scanner;
  import ag32gbd_pkg::*;

  localparam int W    = 32;
  localparam int H    = 16;
  localparam int TO   = 4095;
  localparam int NPIX = W * H;

`ifdef AG32GBD_TILE_FORMAT_EN
  localparam int ABORT_WR = 44;
  localparam logic [7:0] F0 = 8'h55;
  localparam logic [7:0] F2 = 8'hFB;
  localparam logic [7:0] F3 = 8'h0F;
`else
  localparam int ABORT_WR = 45;
  localparam logic [7:0] F0 = 8'h1B;
  localparam logic [7:0] F2 = 8'hFF;
  localparam logic [7:0] F3 = 8'h00;
`endif

  logic sys_clock  = 1'b0;
  logic sys_resetn = 1'b1;
  logic FrameStart = 1'b0;
  logic FrameAbort = 1'b0;
  logic FrameBusy;
  logic FrameDone;
  logic TimeoutFlag;

  ag32gbd_frame_scanner_if bus();

  ag32gbd_frame_scanner #(
    .IMG_W          (W),
    .IMG_H          (H),
    .SAMPLE_TIMEOUT (TO)
  ) dut (
    .sys_clock   (sys_clock),
    .sys_resetn  (sys_resetn),
    .FrameStart  (FrameStart),
    .FrameAbort  (FrameAbort),
    .FrameBusy   (FrameBusy),
    .FrameDone   (FrameDone),
    .TimeoutFlag (TimeoutFlag),
    .bus         (bus)
  );

  always #5 sys_clock = ~sys_clock;

  int tests = 0;
  int fails = 0;
  int wrIdx = 0;
  int doneCnt = 0;
  bit chk = 1'b0;
  logic [7:0] firstData = '0;
  logic [11:0] eA[$];
  logic [7:0]  eD[$];

  int pat = 0;
  int stuckX = -1;
  int stuckY = -1;

  function automatic logic [1:0] shade(int p, int x, int y);
    case (p)
      0: return 2'((x + y) & 3);
      1: return 2'd3;
      default: return 2'((x >> 2) & 3);
    endcase
  endfunction

  // sampler model: done follows start by one cycle
  assign bus.SampledValue =
    shade(pat, int'(bus.PixelX), int'(bus.PixelY));

  always @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) bus.SampleDone <= 1'b0;
    else bus.SampleDone <= bus.SampleStart &&
      !(int'(bus.PixelX) == stuckX && int'(bus.PixelY) == stuckY);
  end

  always @(negedge sys_clock) begin
    if (chk && bus.BufWe) begin
      tests++;
      if (wrIdx >= eA.size()) begin
        fails++;
        $display("FAIL extra_write: got addr %h data %h, want none",
                 bus.BufAddr, bus.BufData);
      end else if (bus.BufAddr !== eA[wrIdx] ||
                   bus.BufData !== eD[wrIdx]) begin
        fails++;
        $display("FAIL write[%0d]: got %h/%h want %h/%h", wrIdx,
                 bus.BufAddr, bus.BufData, eA[wrIdx], eD[wrIdx]);
      end
      if (wrIdx == 0) firstData = bus.BufData;
      wrIdx++;
    end
    if (chk && FrameDone) doneCnt++;
  end

  task automatic check(string name, logic [31:0] got,
                       logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic buildExp(int p, int sx, int sy, int stopIdx);
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] v;
    int x;
    int y;
    eA.delete();
    eD.delete();
    a = '0;
    b = '0;
    for (int i = 0; i < stopIdx; i++) begin
      x = i % W;
      y = i / W;
      v = (x == sx && y == sy) ? 2'b00 : shade(p, x, y);
`ifdef AG32GBD_TILE_FORMAT_EN
      a = {a[6:0], v[0]};
      b = {b[6:0], v[1]};
      if (x % 8 == 7) begin
        eA.push_back(12'(((y / 8) * (W / 8) + x / 8) * 16
                         + (y % 8) * 2));
        eD.push_back(a);
        eA.push_back(12'(((y / 8) * (W / 8) + x / 8) * 16
                         + (y % 8) * 2 + 1));
        eD.push_back(b);
      end
`else
      a = {a[5:0], v};
      if (x % 4 == 3) begin
        eA.push_back(12'(y * (W / 4) + x / 4));
        eD.push_back(a);
      end
`endif
    end
  endtask

  task automatic startFrame();
    FrameStart = 1'b1;
    @(posedge sys_clock);
    #1;
    FrameStart = 1'b0;
  endtask

  typedef struct {
    int pat;
    int sx;
    int sy;
    int ax;
    int ay;
    int pulse;
    int expWr;
    int expDone;
    int expTo;
    logic [7:0] expFirst;
  } vec_t;

  vec_t tbl[4];

  task automatic runVec(input vec_t v, input string tag);
    int n;
    pat = v.pat;
    stuckX = v.sx;
    stuckY = v.sy;
    buildExp(v.pat, v.sx, v.sy,
             (v.ax < 0) ? NPIX : v.ay * W + v.ax);
    wrIdx = 0;
    doneCnt = 0;
    chk = 1'b1;
    startFrame();
    check({tag, "_busy"}, 32'(FrameBusy), 32'd1);
    check({tag, "_toclr"}, 32'(TimeoutFlag), 32'd0);
    check({tag, "_x0y0"},
          32'({bus.SampleStart, bus.PixelX, bus.PixelY}),
          32'({1'b1, 14'd0}));
    n = 0;
    if (v.ax >= 0) begin
      while (!(bus.SampleStart && int'(bus.PixelX) == v.ax &&
               int'(bus.PixelY) == v.ay) && n < 20000) begin
        @(posedge sys_clock);
        #1;
        n++;
      end
      check({tag, "_reach"}, 32'(n < 20000), 32'd1);
      FrameAbort = 1'b1;
      @(posedge sys_clock);
      #1;
      FrameAbort = 1'b0;
      check({tag, "_ss_low"}, 32'(bus.SampleStart), 32'd0);
      check({tag, "_idle"}, 32'(FrameBusy), 32'd0);
      repeat (60) @(posedge sys_clock);
      #1;
    end else begin
      while (!FrameDone && n < 20000) begin
        @(posedge sys_clock);
        #1;
        n++;
        FrameStart = (v.pulse != 0) && (n == 100 || n == 300);
      end
      FrameStart = 1'b0;
      check({tag, "_done_seen"}, 32'(n < 20000), 32'd1);
      @(posedge sys_clock);
      #1;
      check({tag, "_busy_drop"}, 32'(FrameBusy), 32'd0);
      check({tag, "_done_1cyc"}, 32'(FrameDone), 32'd0);
      repeat (20) @(posedge sys_clock);
      #1;
      check({tag, "_no_restart"}, 32'(FrameBusy), 32'd0);
    end
    check({tag, "_writes"}, 32'(wrIdx), 32'(v.expWr));
    check({tag, "_donecnt"}, 32'(doneCnt), 32'(v.expDone));
    check({tag, "_toflag"}, 32'(TimeoutFlag), 32'(v.expTo));
    check({tag, "_first"}, 32'(firstData), 32'(v.expFirst));
    chk = 1'b0;
  endtask

  initial begin
    tbl[0] = '{0, -1, -1, -1, -1, 0, 128, 1, 0, F0};
    tbl[1] = '{1, -1, -1, -1, -1, 1, 128, 1, 0, 8'hFF};
    tbl[2] = '{1, 5, 0, -1, -1, 0, 128, 1, 1, F2};
    tbl[3] = '{2, -1, -1, 20, 5, 0, ABORT_WR, 0, 0, F3};

    #3 sys_resetn = 1'b0;
    #1;
    check("rst_outs",
          32'({bus.SampleStart, bus.BufWe, FrameBusy,
               FrameDone, TimeoutFlag}), 32'd0);
    check("rst_pix", 32'({bus.PixelX, bus.PixelY}), 32'd0);
    check("rst_buf", 32'({bus.BufAddr, bus.BufData}), 32'd0);
    repeat (3) @(posedge sys_clock);
    #1 sys_resetn = 1'b1;
    repeat (2) @(posedge sys_clock);
    #1;

    for (int i = 0; i < 4; i++) begin
      runVec(tbl[i], $sformatf("vec%0d", i));
    end

    FrameAbort = 1'b1;
    FrameStart = 1'b1;
    @(posedge sys_clock);
    #1;
    FrameAbort = 1'b0;
    check("abort_start_same", 32'(FrameBusy), 32'd0);
    repeat (3) @(posedge sys_clock);
    #1;
    check("abort_start_held", 32'(FrameBusy), 32'd0);
    FrameStart = 1'b0;
    repeat (2) @(posedge sys_clock);
    #1;

    pat = 0;
    stuckX = -1;
    stuckY = -1;
    startFrame();
    repeat (200) @(posedge sys_clock);
    #3 sys_resetn = 1'b0;
    #1;
    check("midrst_outs",
          32'({bus.SampleStart, bus.BufWe, FrameBusy,
               FrameDone, TimeoutFlag}), 32'd0);
    check("midrst_pix", 32'({bus.PixelX, bus.PixelY}), 32'd0);
    check("midrst_buf", 32'({bus.BufAddr, bus.BufData}), 32'd0);
    @(posedge sys_clock);
    #1 sys_resetn = 1'b1;
    repeat (2) @(posedge sys_clock);
    #1;
    runVec(tbl[0], "fresh");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
